// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Round-robin share of the register-file write port plus a clear
//            sweep of regs 1..31. Optional counters under RF_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module rf_write_arbiter #(
   parameter int          NUM_REQ = 2,
   parameter logic [31:0] SP_INIT = 32'h3fc
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [5*NUM_REQ-1:0]  req_addr,
   input  logic [32*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  clear_start,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic                  RegWrite,
   output logic [4:0]            Write_register,
   output logic [31:0]           Write_data
`ifdef RF_ARB_STATS_EN
   ,
   output logic [15:0]           grant_count,
   output logic [7:0]            zero_drop_count
`endif
);

   localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
   localparam logic [PTR_W:0]   c_NUM_REQ  = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [PTR_W-1:0]  r_rr_ptr, w_rr_nxt;
   logic              r_we, w_we_nxt;
   logic [4:0]        r_waddr, w_waddr_nxt;
   logic [31:0]       r_wdata, w_wdata_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;

   logic [NUM_REQ-1:0] w_grant;
   logic               w_hs;
   logic [PTR_W-1:0]   w_gnt_idx;
   logic [4:0]         w_sel_addr;
   logic [31:0]        w_sel_data;
   logic [4:0]         w_addr_arr [NUM_REQ];
   logic [31:0]        w_data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_arr[g] = req_addr[5*g +: 5];
      assign w_data_arr[g] = req_data[32*g +: 32];
   end

   // Scan from rr_ptr with wraparound; a clear request or reset blocks all grants.
   always_comb begin
      logic [PTR_W:0]   w_sum;
      logic [PTR_W-1:0] w_idx;
      w_grant    = '0;
      w_hs       = 1'b0;
      w_gnt_idx  = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sum      = '0;
      w_idx      = '0;
      if (reset && (r_state == ARB) && !clear_start) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
               w_sum = w_sum - c_NUM_REQ;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_hs && req_valid[w_idx]) begin
               w_hs          = 1'b1;
               w_grant[w_idx] = 1'b1;
               w_gnt_idx     = w_idx;
               w_sel_addr    = w_addr_arr[w_idx];
               w_sel_data    = w_data_arr[w_idx];
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_we_nxt    = 1'b0;
      w_waddr_nxt = r_waddr;
      w_wdata_nxt = r_wdata;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ARB: begin
            if (clear_start) begin
               w_state_nxt = CLEAR;
               w_we_nxt    = 1'b1;
               w_waddr_nxt = 5'd1;
               w_wdata_nxt = '0;
               w_busy_nxt  = 1'b1;
            end else if (w_hs) begin
               w_rr_nxt = (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + PTR_W'(1);
               // Register 0 is hardwired; the handshake completes but nothing is written.
               if (w_sel_addr != 5'd0) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = w_sel_addr;
                  w_wdata_nxt = w_sel_data;
               end
            end
         end
         CLEAR: begin
            if (r_waddr == 5'd31) begin
               w_state_nxt = ARB;
            end else begin
               w_we_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_waddr_nxt = r_waddr + 5'd1;
               w_wdata_nxt = (w_waddr_nxt == 5'd29) ? SP_INIT : 32'd0;
               w_done_nxt  = (r_waddr == 5'd30);
            end
         end
         default: w_state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ARB;
         r_rr_ptr <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_we     <= w_we_nxt;
         r_waddr  <= w_waddr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

`ifdef RF_ARB_STATS_EN
   logic [15:0] r_grant_cnt;
   logic [7:0]  r_zero_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_grant_cnt <= '0;
         r_zero_cnt  <= '0;
      end else if (w_hs) begin
         r_grant_cnt <= r_grant_cnt + 16'd1;
         if ((w_sel_addr == 5'd0) && (r_zero_cnt != 8'hff)) begin
            r_zero_cnt <= r_zero_cnt + 8'd1;
         end
      end
   end

   assign grant_count     = r_grant_cnt;
   assign zero_drop_count = r_zero_cnt;
`endif

   assign req_ready      = w_grant;
   assign clear_busy     = r_busy;
   assign clear_done     = r_done;
   assign RegWrite       = r_we;
   assign Write_register = r_waddr;
   assign Write_data     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed plus random stimulus for rf_write_arbiter against a
//            cycle-level behavioural model. Counters checked under RF_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

   localparam int          N  = 2;
   localparam logic [31:0] SP = 32'h3fc;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [5*N-1:0]  req_addr;
   logic [32*N-1:0] req_data;
   logic            clear_start;
   logic            clear_busy;
   logic            clear_done;
   logic            RegWrite;
   logic [4:0]      Write_register;
   logic [31:0]     Write_data;
`ifdef RF_ARB_STATS_EN
   logic [15:0]     grant_count;
   logic [7:0]      zero_drop_count;
`endif

   always #5 clk = ~clk;

   rf_write_arbiter #(.NUM_REQ(N), .SP_INIT(SP)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .clear_start    (clear_start),
      .clear_busy     (clear_busy),
      .clear_done     (clear_done),
      .RegWrite       (RegWrite),
      .Write_register (Write_register),
      .Write_data     (Write_data)
`ifdef RF_ARB_STATS_EN
      ,
      .grant_count    (grant_count),
      .zero_drop_count(zero_drop_count)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus for the current cycle
   logic            v_rst   = 1'b0;
   logic [N-1:0]    v_valid = '0;
   logic [5*N-1:0]  v_addr  = '0;
   logic [32*N-1:0] v_data  = '0;
   logic            v_cs    = 1'b0;

   // Model: expected registered outputs for the current cycle
   int          m_rr    = 0;
   int          m_sweep = 0;    // register being written by the sweep this cycle, 0 when arbitrating
   logic        m_we    = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_done  = 1'b0;
   logic [4:0]  m_wa    = '0;
   logic [31:0] m_wd    = '0;
   logic        m_chk_wd = 1'b1;
   int          m_gc    = 0;
   int          m_zc    = 0;
   int          m_gnt   = -1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic step();
      logic [N-1:0] exp_ready;
      logic [4:0]   a;
      logic [31:0]  d;
      int           idx;
      reset       = v_rst;
      req_valid   = v_valid;
      req_addr    = v_addr;
      req_data    = v_data;
      clear_start = v_cs;
      @(negedge clk);
      check_eq("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
      check_eq("clear_busy", {31'd0, clear_busy}, {31'd0, m_busy});
      check_eq("clear_done", {31'd0, clear_done}, {31'd0, m_done});
      if (m_chk_wd) begin
         check_eq("Write_register", {27'd0, Write_register}, {27'd0, m_wa});
         check_eq("Write_data", Write_data, m_wd);
      end
`ifdef RF_ARB_STATS_EN
      check_eq("grant_count", {16'd0, grant_count}, m_gc);
      check_eq("zero_drop_count", {24'd0, zero_drop_count}, m_zc);
`endif
      m_gnt = -1;
      if (v_rst && m_sweep == 0 && !v_cs) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (m_gnt < 0 && v_valid[idx]) m_gnt = idx;
         end
      end
      exp_ready = '0;
      if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
      check_eq("req_ready", {{(32-N){1'b0}}, req_ready}, {{(32-N){1'b0}}, exp_ready});

      if (!v_rst) begin
         m_rr = 0; m_sweep = 0; m_we = 0; m_busy = 0; m_done = 0;
         m_wa = '0; m_wd = '0; m_chk_wd = 1; m_gc = 0; m_zc = 0;
      end else if (m_sweep > 0 || v_cs) begin
         m_sweep = (m_sweep == 31) ? 0 : m_sweep + 1;
         m_we    = (m_sweep > 0);
         m_busy  = m_we;
         m_done  = (m_sweep == 31);
         if (m_we) begin
            m_wa = m_sweep[4:0];
            m_wd = (m_sweep == 29) ? SP : 32'd0;
            m_chk_wd = 1;
         end
      end else begin
         m_busy = 0;
         m_done = 0;
         m_we   = 0;
         if (m_gnt >= 0) begin
            a    = v_addr[5*m_gnt +: 5];
            d    = v_data[32*m_gnt +: 32];
            m_rr = (m_gnt + 1) % N;
            m_gc = (m_gc + 1) % 65536;
            if (a == 5'd0) begin
               if (m_zc < 255) m_zc++;
               m_chk_wd = 0;
            end else begin
               m_we = 1; m_wa = a; m_wd = d; m_chk_wd = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] pend;
      reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
      @(posedge clk);
      #1;

      // Reset held with both requesters valid
      v_rst = 0; v_valid = '1;
      repeat (2) step();
      v_rst = 1; v_valid = '0;
      step();

      // Single write
      v_valid = 2'b01; v_addr = {5'd0, 5'd5}; v_data = {32'd0, 32'hdeadbeef};
      step();
      v_valid = '0;
      repeat (2) step();

      // Register-0 write from requester 1 (leaves rr_ptr at 0)
      v_valid = 2'b10; v_addr = {5'd0, 5'd5}; v_data = {32'd1, 32'hdeadbeef};
      step();
      v_valid = '0;
      step();

      // Round robin with both valid; granted requester gets fresh data
      v_valid = 2'b11; v_addr = {5'd9, 5'd7}; v_data = {32'hb000_0000, 32'ha000_0000};
      for (int c = 0; c < 4; c++) begin
         step();
         if (m_gnt >= 0) v_data[32*m_gnt +: 32] = $urandom;
      end
      v_valid = '0;
      step();

      // Sweep with req0 waiting and a redundant clear_start mid-sweep
      v_valid = 2'b01; v_addr = {5'd0, 5'd3}; v_data = {32'd0, 32'h55};
      v_cs = 1; step(); v_cs = 0;
      for (int c = 1; c <= 31; c++) begin
         v_cs = (c == 5);
         step();
      end
      v_cs = 0;
      step();                 // t+32: grant
      v_valid = '0;
      repeat (2) step();      // t+33: write

      // Abort a sweep with reset, then restart it
      v_cs = 1; step(); v_cs = 0;
      repeat (9) step();
      v_rst = 0; step();
      v_rst = 1; step();
      v_cs = 1; step(); v_cs = 0;
      repeat (35) step();

      // Random traffic
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom % 3 == 0)) begin
               pend[i] = 1'b1;
               v_addr[5*i +: 5]   = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
               v_data[32*i +: 32] = $urandom;
            end
         end
         v_valid = pend;
         v_cs    = ($urandom % 60 == 0);
         v_rst   = ($urandom % 150 != 0);
         step();
         if (m_gnt >= 0) pend[m_gnt] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite / Write_register / Write_data) among NUM_REQ requesters, e.g. core writeback and a debug/boot loader.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Contains a clear sequencer that walks registers 1..31 to their post-reset values ($sp = SP_INIT, all others 0) without a global reset.
- Sits between the requesters and the register-file write port; outputs are registered.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- SP_INIT, 32'h3fc: value written to register 29 during a clear sweep.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  5*NUM_REQ  packed register indices; requester i uses bits [5i+4:5i].
- req_data  in  32*NUM_REQ  packed write data; requester i uses bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- clear_start  in  1  one-cycle pulse that starts a clear sweep.
- clear_busy  out  1  high while the sweep owns the port.
- clear_done  out  1  one-cycle pulse on the final sweep write.
- RegWrite  out  1  to register-file write enable.
- Write_register  out  5  to register-file write address.
- Write_data  out  32  to register-file write data.

Behaviour:
- States: ARB, CLEAR.
- Reset (reset==0 at an edge):
  - state=ARB, rr_ptr=0, sweep index=1.
  - RegWrite=0, Write_register=0, Write_data=0, clear_busy=0, clear_done=0.
  - req_ready=0 while reset is low.
- Reset mid-sweep: abandon the sweep immediately; no further sweep writes.
- ARB, arbitration:
  - Grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot of the granted index; all zeros if no req_valid bit is set.
  - Handshake = req_valid[i] & req_ready[i]; requesters hold addr/data stable until handshake.
- ARB, write latency:
  - A handshake in cycle t drives RegWrite=1, Write_register=addr, Write_data=data in cycle t+1, for exactly one cycle.
  - With no handshake, RegWrite=0 the next cycle; Write_register/Write_data hold their last values.
- ARB, pointer update: after a grant to i, rr_ptr <= (i+1) mod NUM_REQ; with no grant, rr_ptr is unchanged.
- Writes to register 0: still handshaken (ready asserted, pointer advances), but RegWrite stays 0 in t+1.
- clear_start in ARB:
  - Sampled high in cycle t: no grant that cycle (req_ready=0, clear wins over requests); state -> CLEAR.
  - Cycles t+1..t+31: clear_busy=1, RegWrite=1, Write_register = 1,2,...,31 in order.
  - Write_data = SP_INIT when Write_register==29, otherwise 0.
  - clear_done=1 only in cycle t+31 (the register-31 write).
  - Cycle t+31 is still CLEAR; req_ready=0 in all cycles t..t+31.
  - State returns to ARB and arbitration resumes in cycle t+32; a handshake there writes in t+33.
  - rr_ptr is preserved across the sweep.
- clear_start while in CLEAR: ignored; no restart, no extension.
- req_valid while in CLEAR: not granted; requests wait (no loss, since no handshake occurred).

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined:
  - Adds output grant_count (16 bits) and output zero_drop_count (8 bits); both reset to 0.
  - grant_count increments on every handshake, including writes to register 0; wraps 16'hffff -> 0.
  - zero_drop_count increments on each handshake with addr==0; saturates at 8'hff.
  - Neither counter increments on sweep writes.
- Not defined: the ports do not exist and there is no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=2'b11 -> req_ready=00, RegWrite=0, Write_register=0, Write_data=0, clear_busy=0.
- Single write: req0 valid, addr=5, data=32'hdeadbeef in cycle t -> req_ready=01 in t; in t+1, RegWrite=1, Write_register=5, Write_data=32'hdeadbeef; in t+2, RegWrite=0.
- Round-robin: NUM_REQ=2, both valid for 4 cycles, rr_ptr=0 -> grants 0,1,0,1; writes appear one cycle after each grant with the matching addr/data.
- Register 0: req1 writes addr=0, data=1 -> req_ready[1]=1, RegWrite stays 0 next cycle; with RF_ARB_STATS_EN, zero_drop_count=1 and grant_count=1.
- Sweep: clear_start in t with req0 valid -> no grant in t..t+31; writes to registers 1..31 in t+1..t+31, with register 29 receiving 32'h3fc; clear_done only in t+31; req0 granted in t+32 and written in t+33.
- Abort: reset=0 in t+10 of a sweep -> RegWrite=0 and clear_busy=0 from t+11; a clear_start pulse in t+12 gives a fresh sweep starting at register 1 in t+13.
